// File: rtl/mlkem_pkg.sv
// ML-KEM constants and the shared coefficient type used by the
// decode/compress stages.
package mlkem_pkg;

  localparam int Q        = 3329;
  localparam int N_COEFFS = 256;
  localparam int COEFF_W  = 12;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out stream bundle for byte_decode_stream.
// The decoder uses the slave side.
interface byte_decode_stream_if
  import mlkem_pkg::*;
#(
  parameter int IN_BYTES = 1
);

  logic                     in_valid;
  logic                     in_ready;
  logic [IN_BYTES-1:0][7:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  coeff_t                   out_coeff;
  logic                     out_noncanon;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_coeff, out_noncanon, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_coeff, out_noncanon, out_last
  );

endinterface

// File: rtl/mod_q_reduce.sv
// Single conditional subtract of q. Values are 12-bit, so they are < 2q
// and one subtract always lands in 0..q-1.
module mod_q_reduce
  import mlkem_pkg::*;
(
  input  logic [11:0] raw,
  output coeff_t      coeff,
  output logic        noncanon
);

  localparam logic [11:0] Q12 = 12'(Q);

  assign noncanon = (raw >= Q12);
  assign coeff    = noncanon ? coeff_t'(raw - Q12) : coeff_t'(raw);

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: packs input bytes into a bit buffer and emits one
// D-bit coefficient per handshake, reduced mod q when D is 12.
module byte_decode_stream
  import mlkem_pkg::*;
#(
  parameter int D        = 12,
  parameter int IN_BYTES = 1
)
(
  input  logic                 clk,
  input  logic                 rst,
  byte_decode_stream_if.slave  bus
);

  localparam int W      = 8 * IN_BYTES;
  localparam int BUF_W  = W + D - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);

  localparam logic [FILL_W-1:0] D_F = FILL_W'(D);
  localparam logic [FILL_W-1:0] W_F = FILL_W'(W);

  if (D < 1 || D > 12) begin : g_bad_d
    $error("byte_decode_stream: D=%0d outside 1..12", D);
  end
  if (IN_BYTES != 1 && IN_BYTES != 2 && IN_BYTES != 4 &&
      IN_BYTES != 8 && IN_BYTES != 16 && IN_BYTES != 32) begin : g_bad_in_bytes
    $error("byte_decode_stream: IN_BYTES=%0d not a supported width", IN_BYTES);
  end

  logic [BUF_W-1:0]  bit_buf;
  logic [FILL_W-1:0] fill;
  logic [7:0]        idx;
  logic              accept;
  logic              emit;
  coeff_t            raw;

  // Ready/valid come from fill only, so they can never both be high.
  assign bus.in_ready  = ~rst & (fill <  D_F);
  assign bus.out_valid = ~rst & (fill >= D_F);
  assign accept        = bus.in_valid  & bus.in_ready;
  assign emit          = bus.out_valid & bus.out_ready;

  // Bits above fill are always zero, so OR-ing in the shifted beat is a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf <= '0;
      fill    <= '0;
      idx     <= '0;
    end else if (accept) begin
      bit_buf <= bit_buf | (BUF_W'(bus.in_data) << fill);
      fill    <= fill + W_F;
    end else if (emit) begin
      bit_buf <= bit_buf >> D;
      fill    <= fill - D_F;
      idx     <= idx + 8'd1;
    end
  end

  assign raw = COEFF_W'(bit_buf[D-1:0]);

  if (D == COEFF_W) begin : g_reduce
    mod_q_reduce u_reduce (
      .raw      (raw),
      .coeff    (bus.out_coeff),
      .noncanon (bus.out_noncanon)
    );
  end else begin : g_pass
    assign bus.out_coeff    = raw;
    assign bus.out_noncanon = 1'b0;
  end

  assign bus.out_last = bus.out_valid & (idx == 8'hFF);

endmodule

// File: tb/tb_byte_decode_stream.sv
// Bench for byte_decode_stream: three configurations checked against a
// bit-queue reference model, plus table vectors and directed corner cases.
module tb_byte_decode_stream;
  import mlkem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_decode_stream_if #(.IN_BYTES(1)) bus0 ();
  byte_decode_stream_if #(.IN_BYTES(1)) bus1 ();
  byte_decode_stream_if #(.IN_BYTES(4)) bus2 ();

  byte_decode_stream #(.D(12), .IN_BYTES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  byte_decode_stream #(.D(1),  .IN_BYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  byte_decode_stream #(.D(12), .IN_BYTES(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        iv   [3];
  logic        ordy [3];
  logic [31:0] id   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        onc  [3];
  logic        ol   [3];
  logic [11:0] oc   [3];

  assign bus0.in_valid = iv[0];  assign bus0.in_data = id[0][7:0];  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid = iv[1];  assign bus1.in_data = id[1][7:0];  assign bus1.out_ready = ordy[1];
  assign bus2.in_valid = iv[2];  assign bus2.in_data = id[2];       assign bus2.out_ready = ordy[2];

  assign ir[0] = bus0.in_ready;  assign ov[0] = bus0.out_valid;  assign oc[0] = bus0.out_coeff;
  assign onc[0] = bus0.out_noncanon;  assign ol[0] = bus0.out_last;
  assign ir[1] = bus1.in_ready;  assign ov[1] = bus1.out_valid;  assign oc[1] = bus1.out_coeff;
  assign onc[1] = bus1.out_noncanon;  assign ol[1] = bus1.out_last;
  assign ir[2] = bus2.in_ready;  assign ov[2] = bus2.out_valid;  assign oc[2] = bus2.out_coeff;
  assign onc[2] = bus2.out_noncanon;  assign ol[2] = bus2.out_last;

  function automatic int dk(input int k);
    return (k == 1) ? 1 : 12;
  endfunction

  function automatic int nb(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: a plain bit queue per instance, LSB of byte 0 first.
  bit mbits [3][4096];
  int head [3];
  int tail [3];
  int midx [3];
  int ecnt [3];
  int lcnt [3];

  function automatic int peek_raw(input int k);
    int raw = 0;
    for (int b = 0; b < dk(k); b++)
      if (mbits[k][(head[k] + b) % 4096]) raw += (1 << b);
    return raw;
  endfunction

  function automatic int exp_coeff(input int k);
    int raw = peek_raw(k);
    return (dk(k) == 12 && raw >= Q) ? raw - Q : raw;
  endfunction

  task automatic observe(input int k);
    int avail;
    int raw;
    avail = tail[k] - head[k];
    if (rst) begin
      head[k] = 0; tail[k] = 0; midx[k] = 0;
      return;
    end
    chk("in_ready", k, int'(ir[k]), int'(avail < dk(k)));
    chk("out_valid", k, int'(ov[k]), int'(avail >= dk(k)));
    if (avail >= dk(k)) begin
      raw = peek_raw(k);
      chk("coeff", k, int'(oc[k]), exp_coeff(k));
      chk("noncanon", k, int'(onc[k]), int'(dk(k) == 12 && raw >= Q));
      chk("last", k, int'(ol[k]), int'(midx[k] == N_COEFFS - 1));
      if (ordy[k]) begin
        head[k] += dk(k);
        midx[k] = (midx[k] + 1) % N_COEFFS;
        ecnt[k]++;
        if (ol[k]) lcnt[k]++;
      end
    end else if (iv[k]) begin
      for (int b = 0; b < 8 * nb(k); b++) mbits[k][(tail[k] + b) % 4096] = id[k][b];
      tail[k] += 8 * nb(k);
    end
  endtask

  always @(negedge clk) for (int k = 0; k < 3; k++) observe(k);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] v);
    int t = 0;
    iv[k] = 1'b1;
    id[k] = v;
    while (!ir[k] && t < 100) begin tick(); t++; end
    chk("push_wait", k, int'(t < 100), 1);
    tick();
    iv[k] = 1'b0;
  endtask

  task automatic pop(input int k, output int c, output int n, output int l);
    int t = 0;
    ordy[k] = 1'b1;
    while (!ov[k] && t < 100) begin tick(); t++; end
    chk("pop_wait", k, int'(t < 100), 1);
    c = int'(oc[k]);
    n = int'(onc[k]);
    l = int'(ol[k]);
    tick();
    ordy[k] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int c0, c1, n0, n1;
  } tvec_t;

  tvec_t tv [3];

  initial begin
    int c, n, l, t, e0, l0, ec;
    logic [7:0] pat;

    tv[0] = '{8'h01, 8'h23, 8'h45, 769, 1106, 0, 0};
    tv[1] = '{8'hFF, 8'hFF, 8'hFF, 766, 766, 1, 1};
    tv[2] = '{8'h00, 8'h0D, 8'hD0, 3328, 3328, 0, 0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; id[k] = '0;
      head[k] = 0; tail[k] = 0; midx[k] = 0; ecnt[k] = 0; lcnt[k] = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, int'(ir[k]), 0);
      chk("rst_out_valid", k, int'(ov[k]), 0);
      chk("rst_coeff", k, int'(oc[k]), 0);
      chk("rst_noncanon", k, int'(onc[k]), 0);
      chk("rst_last", k, int'(ol[k]), 0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("post_rst_in_ready", k, int'(ir[k]), 1);

    // Table vectors on D=12, one byte per beat.
    for (int i = 0; i < 3; i++) begin
      push(0, {24'd0, tv[i].b0});
      push(0, {24'd0, tv[i].b1});
      pop(0, c, n, l);
      chk("tv_c0", i, c, tv[i].c0);
      chk("tv_n0", i, n, tv[i].n0);
      push(0, {24'd0, tv[i].b2});
      pop(0, c, n, l);
      chk("tv_c1", i, c, tv[i].c1);
      chk("tv_n1", i, n, tv[i].n1);
    end

    // D=1: one bit per coefficient, LSB first.
    pat = 8'hA5;
    push(1, {24'd0, pat});
    for (int i = 0; i < 8; i++) begin
      pop(1, c, n, l);
      chk("d1_bit", i, c, int'(pat[i]));
      chk("d1_last", i, l, 0);
    end

    // Full frame on D=12, 4 bytes per beat.
    e0 = ecnt[2]; l0 = lcnt[2];
    iv[2] = 1'b1; ordy[2] = 1'b1; t = 0;
    while (ecnt[2] - e0 < N_COEFFS && t < 2000) begin id[2] = $urandom; tick(); t++; end
    iv[2] = 1'b0; ordy[2] = 1'b0;
    chk("frame_coeffs", 2, ecnt[2] - e0, N_COEFFS);
    chk("frame_lasts", 2, lcnt[2] - l0, 1);
    chk("frame_end_in_ready", 2, int'(ir[2]), 1);
    chk("frame_end_out_valid", 2, int'(ov[2]), 0);
    push(2, 32'h0000_0ABC);
    pop(2, c, n, l);
    chk("frame2_c0", 2, c, 2748);
    chk("frame2_last", 2, l, 0);

    // Backpressure: 20 bits remain, so a coefficient is pending.
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", i, int'(ov[2]), 1);
      chk("bp_in_ready", i, int'(ir[2]), 0);
      chk("bp_coeff", i, int'(oc[2]), exp_coeff(2));
      tick();
    end
    pop(2, c, n, l);

    // Random traffic on all three instances.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom % 4) != 0;
        id[k]   = $urandom;
        ordy[k] = ($urandom % 3) != 0;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end
    tick();

    // Reset mid-frame at coefficient 100.
    iv[2] = 1'b1; ordy[2] = 1'b1; t = 0;
    while (midx[2] != 100 && t < 3000) begin id[2] = $urandom; tick(); t++; end
    chk("reach_100", 2, int'(t < 3000), 1);
    rst = 1'b1; iv[2] = 1'b0; ordy[2] = 1'b0;
    tick();
    chk("mid_rst_in_ready", 2, int'(ir[2]), 0);
    chk("mid_rst_out_valid", 2, int'(ov[2]), 0);
    chk("mid_rst_coeff", 2, int'(oc[2]), 0);
    chk("mid_rst_noncanon", 2, int'(onc[2]), 0);
    chk("mid_rst_last", 2, int'(ol[2]), 0);
    rst = 1'b0;
    e0 = ecnt[2]; l0 = lcnt[2];
    iv[2] = 1'b1; ordy[2] = 1'b1; t = 0;
    while (lcnt[2] == l0 && t < 3000) begin id[2] = $urandom; tick(); t++; end
    iv[2] = 1'b0; ordy[2] = 1'b0;
    ec = ecnt[2] - e0;
    chk("post_rst_frame_len", 2, ec, N_COEFFS);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/byte_decode_stream.md
Name: byte_decode_stream

Overview:
- Streaming ML-KEM ByteDecode_d stage, downstream of byte-to-bit conversion.
- Accepts packed bytes on a valid/ready input and emits one D-bit polynomial coefficient per handshake.
- Frames are 256 coefficients; out_last marks the final coefficient of each frame.
- For D=12, each coefficient is reduced mod q=3329 and flagged when the input was non-canonical. This is the encapsulation-key modulus check.

Parameters:
- D, 12, coefficient bit width; legal range 1..12.
- IN_BYTES, 1, bytes per input beat; legal values 1, 2, 4, 8, 16, 32. Elaboration-time assertion on both D and IN_BYTES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  [IN_BYTES-1:0][7:0]  packed bytes; byte i occupies stream bits i*8..i*8+7, LSB first
- out_valid  out  1  coefficient available
- out_ready  in  1  downstream accepts
- out_coeff  out  12  coefficient, zero-extended when D<12
- out_noncanon  out  1  D=12 only: raw value was >= 3329 (always 0 when D<12)
- out_last  out  1  coefficient index 255 of the current frame

Behaviour:
- Definitions:
  - W = 8*IN_BYTES.
  - Bit buffer buf has width BUF_W = W+D-1.
  - fill is the valid-bit count (0..BUF_W).
  - idx is the coefficient counter (8 bits).
- Reset, and any cycle with rst=1: fill=0, buf=0, idx=0, in_ready=0, out_valid=0, out_coeff=0, out_noncanon=0, out_last=0. A partial frame is discarded and not resumed.
- in_ready = (fill < D), driven from registers only. It has no combinational path from out_ready or in_valid.
- out_valid = (fill >= D), driven from registers only.
- in_ready and out_valid are mutually exclusive. Accept and emit therefore never occur in the same cycle.
- Accept (in_valid & in_ready): buf[fill +: W] <= in_data; fill <= fill+W.
- Emit (out_valid & out_ready):
  - buf <= buf >> D; fill <= fill-D.
  - idx <= idx+1, wrapping 255 -> 0.
- Output derivation:
  - raw = buf[D-1:0].
  - For D=12: out_coeff = (raw >= 3329) ? raw-3329 : raw, and out_noncanon = (raw >= 3329).
  - For D<12: out_coeff = raw, and out_noncanon = 0.
  - All outputs derive combinationally from registered buf and idx. First-coefficient latency is 1 cycle after the accepting edge.
- out_last = out_valid & (idx == 255).
- Frame alignment: 256*D bits = 32*D bytes, an exact multiple of IN_BYTES. fill is therefore 0 after the out_last handshake, and the next frame starts aligned with no carry-over.
- Backpressure: while out_valid=1 and out_ready=0, out_coeff, out_noncanon and out_last are held stable. in_valid and in_data are ignored while in_ready=0.
- Throughput:
  - With W >= D: floor-free accept/emit alternation. Average is D/W accept cycles per coefficient plus 1 emit cycle.
  - With W < D: ceil(D/W) accepts per coefficient.
- Arithmetic:
  - fill is clog2(BUF_W+1) bits wide.
  - No overflow: accept occurs only when fill <= D-1, so fill+W <= BUF_W.
- No error or abort input. Frame restart requires rst.

Decomposition:
- Package mlkem_pkg:
  - Q=3329, N_COEFFS=256, COEFF_W=12.
  - typedef coeff_t (logic [11:0]).
- Sub-module mod_q_reduce: combinational conditional subtract, raw[11:0] -> coeff_t plus a noncanon flag. It is reused later by compress/decompress stages.

Test Plan:
- D=12, IN_BYTES=1, stream 0x01,0x23,0x45:
  - coeff0=769 (0x301), coeff1=1106 (0x452), noncanon=0.
  - in_ready low for exactly the cycles where fill>=12.
- D=12, bytes 0xFF,0xFF,0xFF: two coefficients of 766, each with out_noncanon=1. Bytes 0x00,0x0D,0xD0 (raw 3328 and 3328): both output 3328 with noncanon=0.
- D=1, IN_BYTES=1, byte 0xA5: bits 1,0,1,0,0,1,0,1 on consecutive handshakes.
- D=12, IN_BYTES=4, full frame of 96 beats:
  - Exactly 256 coefficients, out_last only on the 256th, fill=0 afterwards.
  - Second frame's first coefficient decodes correctly with idx back at 0.
- Backpressure: out_ready held 0 for 10 cycles mid-frame. Outputs stay stable, in_ready=0, no data lost; the sequence resumes identically once out_ready=1.
- Reset mid-frame:
  - rst asserted at coefficient 100; all outputs reach reset values the next cycle.
  - The new stream decodes from idx 0, and out_last occurs after 256 further coefficients.
